pc_fetch_sequencer: RTL and testbench

- Multi-cycle fetch/branch sequencer that owns the architectural PC register.
- Issues instruction-memory reads, hands each instruction to decode, then waits for branch resolution.
- Computes the next PC from the resolution inputs: taken = Uncondbranch | (Branch & ALUZero); target = PC + (SignExtImm64 << 2); otherwise PC + 4.
- Sits between the instruction memory port and the decode/execute stage of the CPU.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/next_pc_calc.sv | 28 ++
 rtl/pc_fetch_sequencer.sv | 111 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-sequencer types and constants: FSM state encoding, PC step and
// branch-offset scaling, and the default architectural reset PC.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_RESOLVE
  } fetch_state_t;

  localparam int PC_INCR = 4;
  localparam int BR_SHIFT = 2;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for a resolved instruction: branch target (word-scaled
// offset) when taken, sequential PC otherwise. Purely combinational.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  input  logic            alu_zero_i,
  input  logic            uncond_i,
  input  logic [PC_W-1:0] imm_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic            taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] seq_pc;

  // Offset bits shifted past the top are dropped; all sums wrap modulo 2^PC_W.
  always_comb begin
    taken     = uncond_i | (branch_i & alu_zero_i);
    target    = pc_i + (imm_i << BR_SHIFT);
    seq_pc    = pc_i + PC_W'(PC_INCR);
    next_pc_o = taken ? target : seq_pc;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/branch sequencer owning the architectural PC: request,
// wait for the instruction, hand it to decode, then apply branch resolution.
module pc_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Run,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               resolve_valid,
  input  logic               Branch,
  input  logic               ALUZero,
  input  logic               Uncondbranch,
  input  logic [PC_W-1:0]    SignExtImm64,
  output logic [PC_W-1:0]    CurrentPC,
  output logic               busy,
  output logic [CNT_W-1:0]   retire_count
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic [PC_W-1:0]    resolved_pc;

  next_pc_calc #(
    .PC_W(PC_W)
  ) u_next_pc (
    .pc_i      (pc_q),
    .branch_i  (Branch),
    .alu_zero_i(ALUZero),
    .uncond_i  (Uncondbranch),
    .imm_i     (SignExtImm64),
    .next_pc_o (resolved_pc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retire_q   <= retire_d;
    end
  end

  // Each handshake input is only looked at in its own state, so stray pulses elsewhere are inert.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retire_d   = retire_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (resolve_valid) begin
          pc_d     = resolved_pc;
          retire_d = retire_q + CNT_W'(1);
          state_d  = Run ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == ST_ISSUE);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign CurrentPC      = pc_q;
  assign busy           = (state_q != ST_IDLE);
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomised scoreboard bench for pc_fetch_sequencer: the driver pushes expected
// fetch addresses, issued instructions and resolved PCs; a negedge monitor checks them.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset, Run;
  logic        imem_req_ready, imem_rsp_valid, instr_ready, resolve_valid;
  logic        Branch, ALUZero, Uncondbranch;
  logic [31:0] imem_rsp_data;
  logic [63:0] SignExtImm64;

  logic        imem_req_valid, instr_valid, busy;
  logic [63:0] imem_req_addr, instr_pc, CurrentPC;
  logic [31:0] instr, retire_count;

  logic        d2_req_valid, d2_instr_valid, d2_busy;
  logic [63:0] d2_req_addr, d2_instr_pc, d2_pc;
  logic [31:0] d2_instr, d2_retire;

  pc_fetch_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Run(Run),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .resolve_valid(resolve_valid), .Branch(Branch), .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
    .SignExtImm64(SignExtImm64), .CurrentPC(CurrentPC), .busy(busy), .retire_count(retire_count)
  );

  // Second instance shares all stimulus; only its reset PC differs, to exercise wrap-around.
  pc_fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .CLK(CLK), .Reset(Reset), .Run(Run),
    .imem_req_valid(d2_req_valid), .imem_req_addr(d2_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(d2_instr_valid), .instr(d2_instr), .instr_pc(d2_instr_pc), .instr_ready(instr_ready),
    .resolve_valid(resolve_valid), .Branch(Branch), .ALUZero(ALUZero), .Uncondbranch(Uncondbranch),
    .SignExtImm64(SignExtImm64), .CurrentPC(d2_pc), .busy(d2_busy), .retire_count(d2_retire)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_req = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0] req_q[$];
  logic [95:0] iss_q[$];
  logic [95:0] res_q[$];
  logic [63:0] m_pc;
  int unsigned m_retire;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic        req_hold = 1'b0, iss_hold = 1'b0;
  logic [63:0] hold_addr, hold_ipc;
  logic [31:0] hold_instr;
  logic [31:0] last_retire = '0;

  always @(negedge CLK) begin
    logic [63:0] ea;
    logic [95:0] e;
    if (Reset) begin
      req_hold = 1'b0;
      iss_hold = 1'b0;
      last_retire = '0;
    end else begin
      if (req_hold) begin
        check64("req_valid_held", 64'(imem_req_valid), 64'd1);
        check64("req_addr_stable", imem_req_addr, hold_addr);
      end
      if (iss_hold) begin
        check64("instr_valid_held", 64'(instr_valid), 64'd1);
        check64("instr_stable", 64'(instr), 64'(hold_instr));
        check64("instr_pc_stable", instr_pc, hold_ipc);
      end
      if (imem_req_valid && imem_req_ready) begin
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
        end else begin
          ea = req_q.pop_front();
          check64("fetch_addr", imem_req_addr, ea);
        end
      end
      if (instr_valid && instr_ready) begin
        if (iss_q.size() == 0) begin
          total++; bad++;
          $display("FAIL issue_unexpected: got instr %h expected none", instr);
        end else begin
          e = iss_q.pop_front();
          check64("issue_instr", 64'(instr), 64'(e[95:64]));
          check64("issue_pc", instr_pc, e[63:0]);
        end
      end
      if (retire_count != last_retire) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL retire_unexpected: got %0d expected %0d", retire_count, last_retire);
        end else begin
          e = res_q.pop_front();
          check64("resolve_pc", CurrentPC, e[63:0]);
          check64("retire_count", 64'(retire_count), 64'(e[95:64]));
        end
        last_retire = retire_count;
      end
      req_hold   = imem_req_valid && !imem_req_ready;
      hold_addr  = imem_req_addr;
      iss_hold   = instr_valid && !instr_ready;
      hold_instr = instr;
      hold_ipc   = instr_pc;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_in();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0;
    Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0; SignExtImm64 = '0; imem_rsp_data = '0;
  endtask

  // Drive inputs that the current phase must ignore; phase 0..3 = REQ, WAIT, ISSUE, RESOLVE.
  task automatic spurious(input int phase);
    if (phase != 0) imem_req_ready = 1'($urandom);
    if (phase != 1) begin
      imem_rsp_valid = 1'($urandom);
      imem_rsp_data  = $urandom;
    end
    if (phase != 2) instr_ready = 1'($urandom);
    if (phase != 3) begin
      resolve_valid = 1'($urandom);
      Branch = 1'($urandom); ALUZero = 1'($urandom); Uncondbranch = 1'($urandom);
      SignExtImm64 = {$urandom, $urandom};
    end
  endtask

  task automatic wait_out(input int sel, input string name);
    int n = 0;
    while (((sel == 0) ? imem_req_valid : instr_valid) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (((sel == 0) ? imem_req_valid : instr_valid) !== 1'b1) begin
      bad++;
      $display("FAIL %s: got no valid after %0d cycles expected valid", name, n);
    end
  endtask

  task automatic run_instr(input int s_req, input int s_rsp, input int s_iss, input int s_res,
                           input logic br, input logic z, input logic un, input logic [63:0] imm,
                           input logic run_next, input logic noise);
    logic [31:0] word;
    logic [63:0] pc_before;
    logic        taken;
    word = $urandom;
    pc_before = m_pc;
    Run = 1'b1;
    req_q.push_back(m_pc);
    wait_out(0, "req_timeout");
    t_req = cyc;
    repeat (s_req) begin clear_in(); if (noise) spurious(0); tick(); end
    clear_in();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'($urandom);
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    Run = run_next;
    repeat (s_rsp) begin clear_in(); if (noise) spurious(1); tick(); end
    clear_in();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    iss_q.push_back({word, m_pc});
    tick();
    clear_in();
    wait_out(1, "issue_timeout");
    repeat (s_iss) begin clear_in(); if (noise) spurious(2); tick(); end
    clear_in();
    instr_ready = 1'b1;
    tick();
    repeat (s_res) begin clear_in(); if (noise) spurious(3); tick(); end
    clear_in();
    resolve_valid = 1'b1; Branch = br; ALUZero = z; Uncondbranch = un; SignExtImm64 = imm;
    taken = un | (br & z);
    m_pc = taken ? (m_pc + imm * 4) : (m_pc + 64'd4);
    m_retire++;
    res_q.push_back({32'(m_retire), m_pc});
    $display("instr #%0d pc=%h word=%h taken=%0d imm=%h next_pc=%h run=%0d",
             m_retire, pc_before, word, taken, imm, m_pc, run_next);
    tick();
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int sv;
    logic [63:0] imm;
    Reset = 1'b1; Run = 1'b0; clear_in();
    m_pc = 64'h0; m_retire = 0;
    repeat (3) tick();
    check64("rst_pc", CurrentPC, 64'h0);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check64("rst_instr_valid", 64'(instr_valid), 64'd0);
    check64("rst_retire", 64'(retire_count), 64'd0);
    check64("rst_instr", 64'(instr), 64'd0);
    check64("rst_instr_pc", instr_pc, 64'd0);
    check64("rst_wrap_pc", d2_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    Reset = 1'b0;
    tick();
    check64("idle_no_run_busy", 64'(busy), 64'd0);

    // three sequential instructions, immediate handshakes, 4 cycles each
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    check64("wrap_pc_zero", d2_pc, 64'h0);
    check64("wrap_pc_known", 64'($isunknown(d2_pc)), 64'd0);
    t0 = t_req;
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    check64("cycles_per_instr_a", 64'(t_req - t0), 64'd4);
    t0 = t_req;
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    check64("cycles_per_instr_b", 64'(t_req - t0), 64'd4);
    check64("retire_after_three", 64'(retire_count), 64'd3);
    check64("pc_after_three", CurrentPC, 64'hC);

    // branch boundary cases
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 64'd13, 1'b1, 1'b0);
    check64("pc_0x40", CurrentPC, 64'h40);
    run_instr(0, 0, 0, 0, 1'b1, 1'b1, 1'b0, -64'sd2, 1'b1, 1'b0);
    check64("cond_taken_back", CurrentPC, 64'h38);
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    run_instr(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, -64'sd2, 1'b1, 1'b0);
    check64("cond_not_taken", CurrentPC, 64'h44);
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 64'd47, 1'b1, 1'b0);
    check64("pc_0x100", CurrentPC, 64'h100);
    run_instr(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 1'b0);
    check64("uncond_fwd", CurrentPC, 64'h140);

    // every handshake stalled 3 cycles with stray inputs on the others
    run_instr(3, 3, 3, 3, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    run_instr(3, 3, 3, 3, 1'b1, 1'b1, 1'b0, 64'd5, 1'b1, 1'b1);

    // Run dropped during WAIT: instruction completes, then idle with no request
    run_instr(0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check64("run_drop_busy", 64'(busy), 64'd0);
      check64("run_drop_no_req", 64'(imem_req_valid), 64'd0);
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sv = int'($urandom_range(0, 200)) - 100;
      imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'(signed'(sv));
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), imm,
                ($urandom_range(0, 4) != 0), 1'($urandom));
      if (Run == 1'b0) repeat (int'($urandom_range(1, 3))) tick();
    end

    // reset pulsed while the instruction is presented to decode
    Run = 1'b1;
    req_q.push_back(m_pc);
    wait_out(0, "req_timeout");
    clear_in(); imem_req_ready = 1'b1; tick();
    clear_in(); imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
    iss_q.push_back({imem_rsp_data, m_pc});
    tick();
    clear_in();
    wait_out(1, "issue_timeout");
    Reset = 1'b1;
    iss_q.delete();
    m_pc = 64'h0; m_retire = 0;
    #1;
    check64("midrst_busy", 64'(busy), 64'd0);
    check64("midrst_instr_valid", 64'(instr_valid), 64'd0);
    check64("midrst_pc", CurrentPC, 64'h0);
    check64("midrst_retire", 64'(retire_count), 64'd0);
    Run = 1'b0;
    tick();
    Reset = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    clear_in();
    tick();
    check64("stale_rsp_idle", 64'(busy), 64'd0);
    check64("stale_rsp_instr", 64'(instr), 64'd0);
    run_instr(1, 1, 1, 1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
    check64("post_reset_pc", CurrentPC, 64'h4);
    repeat (3) tick();

    check64("req_q_drained", 64'(req_q.size()), 64'd0);
    check64("iss_q_drained", 64'(iss_q.size()), 64'd0);
    check64("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
